pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Parametrised program-counter unit for the multicycle CPU. It is the next generation of the plain PC register. It holds the PC and selects the next PC internally: sequential, branch, jump or register target. It also adds conditional (branch) writes, alignment checking, and a minimal precise-trap mechanism (EPC, bad-address, cause, exception-level bit, return-from-exception). It sits between the control FSM/ALU and the instruction-memory address port.

## Interface
- WIDTH, 32, PC/address width in bits
- RESET_VEC, 32'h0000_3000, PC value after reset
- TRAP_VEC, 32'h0000_4180, PC value loaded on any trap
- INC, 4, sequential increment added to PC
- ALIGN_BITS, 2, low PC bits that must be zero

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- pc_write  input  1  unconditional PC update this cycle
- pc_write_cond  input  1  PC update only if zero=1 (branch)
- zero  input  1  ALU zero flag
- npc_sel  input  2  00 PC+INC, 01 br_target, 10 j_target, 11 reg_target
- br_target  input  WIDTH  branch target address
- j_target  input  WIDTH  jump target address
- reg_target  input  WIDTH  register-indirect target (jr)
- trap_req  input  1  external/instruction trap request (one-cycle strobe)
- eret  input  1  return from exception
- pc  output  WIDTH  current PC (registered)
- pc_inc  output  WIDTH  pc+INC, combinational, modulo 2^WIDTH
- epc  output  WIDTH  exception PC (registered)
- bad_addr  output  WIDTH  last misaligned target (registered)
- cause  output  2  00 none, 01 trap_req, 10 misaligned target
- exl  output  1  exception level; 1 while in handler
- trap_taken  output  1  registered one-cycle pulse after any trap redirect

## Operation
- npc = mux(npc_sel); upd = pc_write | (pc_write_cond & zero).
- mis = upd & (npc[ALIGN_BITS-1:0] != 0); not evaluated when ALIGN_BITS=0.
- Per-edge priority, exactly one action:
  1. rst: pc<=RESET_VEC; epc<=0; bad_addr<=0; cause<=00; exl<=0; trap_taken<=0.
  2. trap_req: pc<=TRAP_VEC; cause<=01; exl<=1; trap_taken<=1; epc<=pc only if exl was 0.
  3. eret with exl=1: pc<=epc; exl<=0; cause unchanged.
  4. eret with exl=0: ignored, no state change.
  5. mis: pc<=TRAP_VEC; bad_addr<=npc; cause<=10; exl<=1; trap_taken<=1; epc<=pc only if exl was 0.
  6. upd: pc<=npc.
  7. Otherwise: all registers hold.
- Nested trap (exl=1): redirect still happens and cause/bad_addr update; epc keeps the outermost return address.
- trap_taken is 0 in every cycle not following a trap redirect.
- pc_write and pc_write_cond both high: upd is their OR; no error.
- Arithmetic wraps silently: pc=2^WIDTH-INC with npc_sel=00 gives pc_inc=0.

## Timing
- Single clock domain; every output except pc_inc is a flop output.
- Latency: 1 cycle from an asserted control to the new pc/epc/exl values.
- rst sampled only on the rising edge. A reset in the same cycle as trap_req, eret or a write overrides them. No asynchronous clear.
- trap_req and eret are level-sampled each edge. The control FSM must deassert them after one cycle, otherwise they are re-taken.
- After reset, the first edge with rst=0 may update pc.
- pc_inc follows pc combinationally in the same cycle.

## Test plan
- Reset and sequential: assert rst 2 cycles -> pc=0x3000, epc=0, exl=0. Then pc_write, npc_sel=00 for 3 cycles -> pc = 0x3004, 0x3008, 0x300C.
- Conditional branch: pc=0x3010, pc_write_cond=1, npc_sel=01, br_target=0x3100. With zero=0 -> pc stays 0x3010. Next cycle with zero=1 -> pc=0x3100.
- Trap and return: at pc=0x3020 pulse trap_req -> pc=0x4180, epc=0x3020, cause=01, exl=1, trap_taken=1 for one cycle. Then pulse eret -> pc=0x3020, exl=0.
- Misaligned jump: pc=0x3040, pc_write, npc_sel=11, reg_target=0x3042 -> pc=0x4180, bad_addr=0x3042, cause=10, epc=0x3040.
- Nested trap and priority: with exl=1, epc=0x3020, assert trap_req and eret together -> pc=0x4180, epc stays 0x3020, exl=1. Then rst together with trap_req -> pc=0x3000, exl=0.
- Wrap-around: force pc=0xFFFF_FFFC with pc_write, npc_sel=00 -> pc=0x0000_0000, no trap.

Source files
------------

// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Purpose  : Program-counter unit for the multicycle CPU. Holds the PC,
//            selects the next PC (sequential / branch / jump / register),
//            supports conditional (branch) writes, target alignment checking
//            and a minimal precise-trap mechanism (EPC, bad address, cause,
//            exception-level bit, return-from-exception).
//
// Parameters:
//   WIDTH       PC / address width in bits
//   RESET_VEC   PC value after reset
//   TRAP_VEC    PC value loaded on any trap
//   INC         sequential increment added to PC
//   ALIGN_BITS  number of low PC bits that must be zero (0 disables check)
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   pc_write       in   unconditional PC update this cycle
//   pc_write_cond  in   PC update only when zero=1 (branch)
//   zero           in   ALU zero flag
//   npc_sel[1:0]   in   00 PC+INC, 01 br_target, 10 j_target, 11 reg_target
//   br_target      in   branch target address
//   j_target       in   jump target address
//   reg_target     in   register-indirect target
//   trap_req       in   trap request strobe (level-sampled each edge)
//   eret           in   return from exception (level-sampled each edge)
//   pc             out  current PC (registered)
//   pc_inc         out  pc + INC, combinational, modulo 2^WIDTH
//   epc            out  exception PC (registered)
//   bad_addr       out  last misaligned target (registered)
//   cause[1:0]     out  00 none, 01 trap_req, 10 misaligned target
//   exl            out  exception level, 1 while in the handler
//   trap_taken     out  registered one-cycle pulse after a trap redirect
//
// Revision : 1.0  initial release
// ============================================================================
module pc_ctrl #(
    parameter int unsigned           WIDTH      = 32,
    parameter logic [WIDTH-1:0]      RESET_VEC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0]      TRAP_VEC   = 32'h0000_4180,
    parameter int unsigned           INC        = 4,
    parameter int unsigned           ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             zero,
    input  logic [1:0]       npc_sel,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] j_target,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             trap_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] bad_addr,
    output logic [1:0]       cause,
    output logic             exl,
    output logic             trap_taken
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] c_inc = WIDTH'(INC);

    localparam logic [1:0] c_sel_seq = 2'b00;
    localparam logic [1:0] c_sel_br  = 2'b01;
    localparam logic [1:0] c_sel_j   = 2'b10;
    localparam logic [1:0] c_sel_reg = 2'b11;

    localparam logic [1:0] c_cause_none  = 2'b00;
    localparam logic [1:0] c_cause_trap  = 2'b01;
    localparam logic [1:0] c_cause_align = 2'b10;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] pc_q,         pc_d;
    logic [WIDTH-1:0] epc_q,        epc_d;
    logic [WIDTH-1:0] bad_addr_q,   bad_addr_d;
    logic [1:0]       cause_q,      cause_d;
    logic             exl_q,        exl_d;
    logic             trap_taken_q, trap_taken_d;

    // ------------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_npc;
    logic             w_upd;
    logic             w_mis;

    // Plain modular add: wrap past 2^WIDTH is intentional and silent.
    assign w_pc_inc = pc_q + c_inc;

    always_comb begin
        w_npc = w_pc_inc;
        case (npc_sel)
            c_sel_seq: w_npc = w_pc_inc;
            c_sel_br:  w_npc = br_target;
            c_sel_j:   w_npc = j_target;
            c_sel_reg: w_npc = reg_target;
            default:   w_npc = w_pc_inc;
        endcase
    end

    // Asserting both write enables together is legal; they simply OR.
    assign w_upd = pc_write | (pc_write_cond & zero);

    // ------------------------------------------------------------------------
    // Alignment check. With ALIGN_BITS = 0 there are no bits to test, so the
    // check is removed entirely rather than slicing an empty range.
    // ------------------------------------------------------------------------
    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign w_mis = w_upd & (|w_npc[ALIGN_BITS-1:0]);
        end else begin : g_align_none
            assign w_mis = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic. Exactly one action is taken per edge, in priority
    // order: trap request, eret (taken or ignored), misaligned target,
    // ordinary update, hold. Reset is applied in the register block so it
    // overrides everything here.
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        bad_addr_d   = bad_addr_q;
        cause_d      = cause_q;
        exl_d        = exl_q;
        // trap_taken is a pulse: it only survives the cycle after a redirect.
        trap_taken_d = 1'b0;

        if (trap_req) begin
            pc_d         = TRAP_VEC;
            cause_d      = c_cause_trap;
            exl_d        = 1'b1;
            trap_taken_d = 1'b1;
            // A nested trap must not overwrite the outermost return address.
            if (!exl_q) begin
                epc_d = pc_q;
            end
        end else if (eret) begin
            // eret outside the handler is a no-op; inside, it returns to EPC
            // and leaves cause as the record of the last trap.
            if (exl_q) begin
                pc_d  = epc_q;
                exl_d = 1'b0;
            end
        end else if (w_mis) begin
            pc_d         = TRAP_VEC;
            bad_addr_d   = w_npc;
            cause_d      = c_cause_align;
            exl_d        = 1'b1;
            trap_taken_d = 1'b1;
            if (!exl_q) begin
                epc_d = pc_q;
            end
        end else if (w_upd) begin
            pc_d = w_npc;
        end
    end

    // ------------------------------------------------------------------------
    // State registers with synchronous reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            epc_q        <= '0;
            bad_addr_q   <= '0;
            cause_q      <= c_cause_none;
            exl_q        <= 1'b0;
            trap_taken_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            bad_addr_q   <= bad_addr_d;
            cause_q      <= cause_d;
            exl_q        <= exl_d;
            trap_taken_q <= trap_taken_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc         = pc_q;
    assign pc_inc     = w_pc_inc;
    assign epc        = epc_q;
    assign bad_addr   = bad_addr_q;
    assign cause      = cause_q;
    assign exl        = exl_q;
    assign trap_taken = trap_taken_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ctrl
// Purpose  : Self-checking bench for pc_ctrl. Directed scenarios followed by
//            randomized cycles, all compared against a behavioural model of
//            the PC / trap rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_ctrl;

    localparam logic [31:0] c_reset_vec = 32'h0000_3000;
    localparam logic [31:0] c_trap_vec  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst, pc_write, pc_write_cond, zero, trap_req, eret;
    logic [1:0]  npc_sel;
    logic [31:0] br_target, j_target, reg_target;
    logic [31:0] pc, pc_inc, epc, bad_addr;
    logic [1:0]  cause;
    logic        exl, trap_taken;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc, m_bad;
    logic [1:0]  m_cause;
    logic        m_exl, m_tt;

    pc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .npc_sel       (npc_sel),
        .br_target     (br_target),
        .j_target      (j_target),
        .reg_target    (reg_target),
        .trap_req      (trap_req),
        .eret          (eret),
        .pc            (pc),
        .pc_inc        (pc_inc),
        .epc           (epc),
        .bad_addr      (bad_addr),
        .cause         (cause),
        .exl           (exl),
        .trap_taken    (trap_taken)
    );

    always #5 clk = ~clk;

    // Behavioural model: one clock edge applied to the architectural state.
    task automatic model_edge();
        logic [31:0] npc;
        logic        upd, mis;
        case (npc_sel)
            2'd0:    npc = m_pc + 32'd4;
            2'd1:    npc = br_target;
            2'd2:    npc = j_target;
            default: npc = reg_target;
        endcase
        upd = pc_write || (pc_write_cond && zero);
        mis = upd && ((npc % 32'd4) != 32'd0);
        if (rst) begin
            m_pc = c_reset_vec; m_epc = 0; m_bad = 0;
            m_cause = 0; m_exl = 0; m_tt = 0;
        end else begin
            m_tt = 0;
            if (trap_req) begin
                if (!m_exl) m_epc = m_pc;
                m_pc = c_trap_vec; m_cause = 2'd1; m_exl = 1; m_tt = 1;
            end else if (eret) begin
                if (m_exl) begin
                    m_pc = m_epc; m_exl = 0;
                end
            end else if (mis) begin
                if (!m_exl) m_epc = m_pc;
                m_bad = npc; m_pc = c_trap_vec; m_cause = 2'd2; m_exl = 1; m_tt = 1;
            end else if (upd) begin
                m_pc = npc;
            end
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk32({tag, ".pc"},         pc,         m_pc);
        chk32({tag, ".pc_inc"},     pc_inc,     m_pc + 32'd4);
        chk32({tag, ".epc"},        epc,        m_epc);
        chk32({tag, ".bad_addr"},   bad_addr,   m_bad);
        chk32({tag, ".cause"},      {30'd0, cause}, {30'd0, m_cause});
        chk32({tag, ".exl"},        {31'd0, exl},   {31'd0, m_exl});
        chk32({tag, ".trap_taken"}, {31'd0, trap_taken}, {31'd0, m_tt});
    endtask

    // Drive one cycle of inputs, clock it, update the model, check after edge.
    task automatic step(input string tag, input logic r, input logic pw, input logic pwc,
                        input logic z, input logic [1:0] sel, input logic [31:0] br,
                        input logic [31:0] jt, input logic [31:0] rg,
                        input logic tr, input logic er);
        rst = r; pc_write = pw; pc_write_cond = pwc; zero = z; npc_sel = sel;
        br_target = br; j_target = jt; reg_target = rg; trap_req = tr; eret = er;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; pc_write = 0; pc_write_cond = 0; zero = 0; npc_sel = 0;
        br_target = 0; j_target = 0; reg_target = 0; trap_req = 0; eret = 0;
        m_pc = 0; m_epc = 0; m_bad = 0; m_cause = 0; m_exl = 0; m_tt = 0;
        #2;

        // Reset and sequential
        step("rst0", 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        chk32("reset_pc", pc, 32'h0000_3000);
        for (int i = 0; i < 3; i++) step("seq", 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        chk32("seq_pc", pc, 32'h0000_300C);
        step("seq4", 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);

        // Conditional branch: not taken then taken
        step("br_nt", 0, 0, 1, 0, 2'd1, 32'h3100, 0, 0, 0, 0);
        chk32("br_nt_pc", pc, 32'h0000_3010);
        step("br_t",  0, 0, 1, 1, 2'd1, 32'h3100, 0, 0, 0, 0);
        chk32("br_t_pc", pc, 32'h0000_3100);

        // Trap and return
        step("j3020", 0, 1, 0, 0, 2'd2, 0, 32'h3020, 0, 0, 0);
        step("trap",  0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
        chk32("trap_epc", epc, 32'h0000_3020);
        idle("trap_pulse_end");
        step("eret",  0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1);
        chk32("eret_pc", pc, 32'h0000_3020);
        step("eret_noexl", 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1);

        // Misaligned register jump
        step("j3040", 0, 1, 0, 0, 2'd2, 0, 32'h3040, 0, 0, 0);
        step("jr_mis", 0, 1, 0, 0, 2'd3, 0, 0, 32'h3042, 0, 0);
        chk32("mis_bad", bad_addr, 32'h0000_3042);
        step("eret2", 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1);

        // Nested trap with eret together, then reset overriding trap
        step("j3020b", 0, 1, 0, 0, 2'd2, 0, 32'h3020, 0, 0, 0);
        step("trap2",  0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
        step("trap_eret", 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 1);
        chk32("nested_epc", epc, 32'h0000_3020);
        step("nested_mis", 0, 1, 0, 0, 2'd1, 32'h5001, 0, 0, 0, 0);
        step("rst_trap", 1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0);
        chk32("rst_trap_pc", pc, 32'h0000_3000);

        // Wrap-around
        step("jtop", 0, 1, 0, 0, 2'd2, 0, 32'hFFFF_FFFC, 0, 0, 0);
        chk32("top_pc_inc", pc_inc, 32'h0000_0000);
        step("wrap", 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
        chk32("wrap_pc", pc, 32'h0000_0000);

        // Both write enables with zero=0: still an update
        step("both_we", 0, 1, 1, 0, 2'd2, 0, 32'h3200, 0, 0, 0);

        // Randomized cycles
        for (int i = 0; i < 500; i++) begin
            logic [31:0] b, j, g;
            b = $urandom; j = $urandom; g = $urandom;
            if ($urandom_range(3) != 0) b[1:0] = 2'b00;
            if ($urandom_range(3) != 0) j[1:0] = 2'b00;
            if ($urandom_range(3) != 0) g[1:0] = 2'b00;
            step("rand",
                 ($urandom_range(31) == 0),
                 ($urandom_range(1) == 0),
                 ($urandom_range(2) == 0),
                 1'($urandom_range(1)),
                 2'($urandom_range(3)),
                 b, j, g,
                 ($urandom_range(7) == 0),
                 ($urandom_range(7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
